// File: rtl/vga_pixel_sink_if.sv
// Pixel-write stream from draw_grid / raytracer into the sink: one pixel per cycle when vga_write is high.
// No ready signal; the receiver absorbs or drops every presented pixel.
interface vga_pixel_sink_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;

  modport master (output vga_x, vga_y, vga_colour, vga_write);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_write);
endinterface

// File: rtl/vga_pixel_sink.sv
// Pixel FIFO draining into the 160x120x3 framebuffer with a start/done full-screen clear; optional VGA_PIXEL_SINK_DROP_COUNT_EN.
// Pixel to fb_we in 2 cycles; no backpressure: a pixel arriving at a full FIFO is dropped and sets sticky overflow.
module vga_pixel_sink #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  vga_pixel_sink_if.slave      pix,
  input  logic                 clear_start,
  input  logic [2:0]           clear_colour,
  output logic                 clear_done,
  output logic                 busy,
  output logic                 overflow,
  output logic [14:0]          fb_addr,
  output logic [2:0]           fb_data,
  output logic                 fb_we,
  output logic [7:0]           dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [14:0] FB_LAST = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, CLEAR, DONE} state_e;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          mem_q [DEPTH];
  entry_t          head;
  entry_t          push_entry;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [14:0]     clr_addr_q, clr_addr_d;
  logic [2:0]      colour_q, colour_d;
  logic [14:0]     fb_addr_q, fb_addr_d;
  logic [2:0]      fb_data_q, fb_data_d;
  logic            fb_we_q, fb_we_d;
  logic            overflow_q, overflow_d;

  logic            in_range;
  logic            full;
  logic            pop;
  logic            push;

  assign in_range = pix.vga_write
                  && (32'(pix.vga_x) < SCREEN_W)
                  && (32'(pix.vga_y) < SCREEN_H);

  assign full = (count_q == CW'(DEPTH));

  // In FLUSH only the entries queued ahead of the clear may leave; later pixels wait for the clear.
  assign pop  = ((state_q == IDLE)  && (count_q   != '0))
             || ((state_q == FLUSH) && (pre_cnt_q != '0));

  assign push = in_range && (!full || pop);

  assign push_entry.addr   = 15'(32'(pix.vga_y) * SCREEN_W + 32'(pix.vga_x));
  assign push_entry.colour = pix.vga_colour;
  assign head              = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    clr_addr_d = clr_addr_q;
    colour_d   = colour_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    fb_we_d    = 1'b0;
    overflow_d = overflow_q | (in_range & ~push);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    if (pop) begin
      fb_addr_d = head.addr;
      fb_data_d = head.colour;
      fb_we_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d   = FLUSH;
          colour_d  = clear_colour;
          // Post-edge occupancy: includes a same-cycle push, excludes a same-cycle pop.
          pre_cnt_d = count_d;
        end
      end
      FLUSH: begin
        if (pre_cnt_q == '0) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q - CW'(1);
        end
      end
      CLEAR: begin
        fb_addr_d  = clr_addr_q;
        fb_data_d  = colour_q;
        fb_we_d    = 1'b1;
        clr_addr_d = clr_addr_q + 15'd1;
        if (clr_addr_q == FB_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pre_cnt_q  <= '0;
      clr_addr_q <= '0;
      colour_q   <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      clr_addr_q <= clr_addr_d;
      colour_q   <= colour_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

`ifdef VGA_PIXEL_SINK_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       out_range;

  assign out_range  = pix.vga_write && !in_range;
  assign drop_cnt_d = (out_range && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dropped_count = drop_cnt_q;
`else
  assign dropped_count = '0;
`endif

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign overflow   = overflow_q;
  assign clear_done = (state_q == DONE);
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: directed scenarios plus random traffic, every cycle compared with a queue-based reference.
module tb_vga_pixel_sink;
  localparam int DEPTH = 8;
  localparam int W     = 160;
  localparam int H     = 120;
  localparam int NPIX  = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_colour = 3'd0;
  logic        clear_done, busy, overflow, fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic [7:0]  dropped_count;

  vga_pixel_sink_if pix ();

  vga_pixel_sink #(.DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .clock         (clock),
    .reset         (reset),
    .pix           (pix),
    .clear_start   (clear_start),
    .clear_colour  (clear_colour),
    .clear_done    (clear_done),
    .busy          (busy),
    .overflow      (overflow),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .dropped_count (dropped_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: a queue of pending pixels, a count of pixels owed before the clear, and a clear phase.
  logic [17:0] mq[$];
  int          ph = 0;        // 0 idle, 1 draining pre-clear pixels, 2 clearing, 3 done pulse
  int          ahead = 0;
  int          caddr = 0;
  logic [2:0]  ccol = 3'd0;
  logic        m_we = 1'b0;
  logic [14:0] m_addr = 15'd0;
  logic [2:0]  m_data = 3'd0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;

  always @(posedge clock) begin : model
    int sz;
    int ahead0;
    bit popping;
    bit inr;
    if (reset) begin
      mq.delete();
      ph = 0; ahead = 0; caddr = 0; ccol = 3'd0;
      m_we = 1'b0; m_addr = 15'd0; m_data = 3'd0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      sz      = mq.size();
      ahead0  = ahead;
      popping = (ph == 0 && sz > 0) || (ph == 1 && ahead > 0);
      inr     = pix.vga_write && (pix.vga_x < 8'(W)) && (pix.vga_y < 7'(H));
      m_we    = 1'b0;
      if (popping) begin
        {m_addr, m_data} = mq.pop_front();
        m_we = 1'b1;
        if (ph == 1) ahead--;
      end else if (ph == 2) begin
        m_we   = 1'b1;
        m_addr = 15'(caddr);
        m_data = ccol;
      end
      if (inr) begin
        if (sz < DEPTH || popping)
          mq.push_back({15'(int'(pix.vga_y) * W + int'(pix.vga_x)), pix.vga_colour});
        else
          m_ovf = 1'b1;
      end
`ifdef VGA_PIXEL_SINK_DROP_COUNT_EN
      if (pix.vga_write && !inr && m_drop < 255) m_drop++;
`endif
      case (ph)
        0: if (clear_start) begin ph = 1; ccol = clear_colour; ahead = mq.size(); end
        1: if (ahead0 == 0) begin ph = 2; caddr = 0; end
        2: begin if (caddr == NPIX - 1) ph = 3; caddr++; end
        default: ph = 0;
      endcase
    end
  end

  task automatic tick();
    logic [31:0] dv, mv;
    @(negedge clock);
    if (fb_we) wr_cnt++;
    if (clear_done) done_cnt++;
    dv = {2'b00, fb_we, fb_addr, fb_data, clear_done, busy, overflow, dropped_count};
    mv = {2'b00, m_we, m_addr, m_data, (ph == 3), (ph != 0 || mq.size() != 0), m_ovf, 8'(m_drop)};
    check("cycle", dv, mv);
  endtask

  task automatic drive_px(input bit w, input int x, input int y, input int c);
    pix.vga_write  = w;
    pix.vga_x      = 8'(x);
    pix.vga_y      = 7'(y);
    pix.vga_colour = 3'(c);
  endtask

  task automatic rand_px();
    drive_px(1'b1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
  endtask

  initial begin : stim
    int w0, d0, n;
    drive_px(1'b0, 0, 0, 0);
    reset = 1'b1;
    tick(); tick();
    check("rst_outs", {fb_we, fb_addr, fb_data, clear_done, busy, overflow, dropped_count}, 32'd0);
    reset = 1'b0;

    // single pixel latency and address
    drive_px(1'b1, 5, 2, 3);
    tick();
    check("px_cycle1_we", 32'(fb_we), 32'd0);
    drive_px(1'b0, 0, 0, 0);
    tick();
    check("px_we", 32'(fb_we), 32'd1);
    check("px_addr", 32'(fb_addr), 32'd325);
    check("px_data", 32'(fb_data), 32'd3);
    check("px_busy", 32'(busy), 32'd0);
    tick();
    check("px_we_off", 32'(fb_we), 32'd0);

    // out-of-range pixels
    w0 = wr_cnt;
    drive_px(1'b1, 160, 0, 5); tick();
    drive_px(1'b1, 0, 120, 2); tick();
    drive_px(1'b0, 0, 0, 0);
    repeat (3) tick();
    check("rng_writes", 32'(wr_cnt - w0), 32'd0);
    check("rng_ovf", 32'(overflow), 32'd0);
`ifdef VGA_PIXEL_SINK_DROP_COUNT_EN
    check("rng_dropcnt", 32'(dropped_count), 32'd2);
`else
    check("rng_dropcnt", 32'(dropped_count), 32'd0);
`endif

    // clear ordering: 3 pixels, clear, 2 pixels
    w0 = wr_cnt; d0 = done_cnt;
    repeat (3) begin rand_px(); tick(); end
    drive_px(1'b0, 0, 0, 0);
    clear_start = 1'b1; clear_colour = 3'd6;
    tick();
    clear_start = 1'b0;
    repeat (2) begin rand_px(); tick(); end
    drive_px(1'b0, 0, 0, 0);
    wait_done(d0, NPIX + 100);
    check("ord_done", 32'(done_cnt - d0), 32'd1);
    check("ord_writes_at_done", 32'(wr_cnt - w0), 32'(3 + NPIX));
    repeat (5) tick();
    check("ord_writes_total", 32'(wr_cnt - w0), 32'(5 + NPIX));
    check("ord_busy", 32'(busy), 32'd0);

    // burst of 12 during clear with repeated clear_start
    w0 = wr_cnt; d0 = done_cnt;
    clear_start = 1'b1; clear_colour = 3'($urandom_range(0, 7));
    tick();
    clear_start = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 12; i++) begin
      clear_start = (i < 2);
      rand_px();
      tick();
    end
    clear_start = 1'b0;
    drive_px(1'b0, 0, 0, 0);
    wait_done(d0, NPIX + 100);
    check("burst_done", 32'(done_cnt - d0), 32'd1);
    check("burst_clear_writes", 32'(wr_cnt - w0), 32'(NPIX));
    repeat (20) tick();
    check("burst_writes", 32'(wr_cnt - w0), 32'(NPIX + 8));
    check("burst_ovf", 32'(overflow), 32'd1);
    check("burst_single_done", 32'(done_cnt - d0), 32'd1);

    // reset in the middle of a clear
    d0 = done_cnt;
    clear_start = 1'b1; clear_colour = 3'd5;
    tick();
    clear_start = 1'b0;
    repeat (3) begin rand_px(); tick(); end
    drive_px(1'b0, 0, 0, 0);
    n = 0;
    while (!(fb_we && fb_addr == 15'd1000) && n < 2000) begin tick(); n++; end
    check("mid_reached_1000", 32'(fb_addr), 32'd1000);
    reset = 1'b1;
    tick();
    check("mid_rst_outs", {fb_we, fb_addr, fb_data, clear_done, busy, overflow, dropped_count}, 32'd0);
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (100) tick();
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_no_writes", 32'(wr_cnt - w0), 32'd0);

    // random traffic with one clear in the middle
    d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1)
        drive_px(1'b1, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
      else
        drive_px(1'b0, 0, 0, 0);
      clear_start  = (i == 1000);
      clear_colour = 3'($urandom_range(0, 7));
      tick();
    end
    clear_start = 1'b0;
    for (int i = 0; i < NPIX + 100 && done_cnt == d0; i++) begin
      if ($urandom_range(0, 1) == 1) rand_px(); else drive_px(1'b0, 0, 0, 0);
      tick();
    end
    drive_px(1'b0, 0, 0, 0);
    check("rand_done", 32'(done_cnt - d0), 32'd1);
    repeat (20) tick();
    check("rand_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
